// File: rtl/flat_array_reader.sv
`default_nettype none
// ============================================================================
// flat_array_reader : holds one packed ELEM_W x NUM_ELEM array and streams it
// out one element per valid/ready handshake, element 0 first.
// Option macro ARRAY_READER_SUM_EN adds a running element sum (sum_out/sum_valid).
// Revision: 1.0
// ============================================================================
module flat_array_reader #(
  parameter int ELEM_W   = 3,
  parameter int NUM_ELEM = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [ELEM_W*NUM_ELEM-1:0] flat_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic [3:0]                 out_index,
  output logic                       out_last,
  output logic                       busy
`ifdef ARRAY_READER_SUM_EN
  ,
  output logic [ELEM_W+3:0]          sum_out,
  output logic                       sum_valid
`endif
);

  localparam int         FLAT_W   = ELEM_W * NUM_ELEM;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ELEM - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state_q;
  logic [FLAT_W-1:0]   hold_q;
  logic [FLAT_W-1:0]   hold_d;
  logic [3:0]          index_q;
  logic [3:0]          index_d;
  logic                last_q;
  logic                valid_q;
  logic                ready_q;
  logic                w_load;
  logic                w_xfer;

  assign w_load  = load_valid && ready_q;
  assign w_xfer  = valid_q && out_ready;
  // The current element always sits in the low slot; each handshake shifts the next one down.
  assign hold_d  = hold_q >> ELEM_W;
  assign index_d = index_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      index_q <= 4'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_load) begin
            hold_q  <= flat_in;
            index_q <= 4'd0;
            last_q  <= (LAST_IDX == 4'd0);
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            hold_q <= hold_d;
            if (last_q) begin
              index_q <= 4'd0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              index_q <= index_d;
              last_q  <= (index_d == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign out_valid  = valid_q;
  assign out_data   = hold_q[ELEM_W-1:0];
  assign out_index  = index_q;
  assign out_last   = last_q;
  assign busy       = (state_q == STREAM);

`ifdef ARRAY_READER_SUM_EN
  logic [ELEM_W+3:0] sum_q;
  logic              sum_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= w_xfer && last_q;
      if (w_load) begin
        sum_q <= '0;
      end else if (w_xfer) begin
        sum_q <= sum_q + {4'b0000, out_data};
      end
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
`endif

endmodule
`default_nettype wire
